// File: rtl/tag_rx_pkg.sv
// ============================================================================
// Package : tag_rx_pkg
// Brief   : Shared state encodings and width helper for the tag receive
//           slot scheduler.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package tag_rx_pkg;

    localparam logic [2:0] TAG_RX_ST_IDLE      = 3'd0;
    localparam logic [2:0] TAG_RX_ST_ARM       = 3'd1;
    localparam logic [2:0] TAG_RX_ST_SYNC_WAIT = 3'd2;
    localparam logic [2:0] TAG_RX_ST_GUARD     = 3'd3;
    localparam logic [2:0] TAG_RX_ST_SLOT      = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = TAG_RX_ST_IDLE,
        ST_ARM       = TAG_RX_ST_ARM,
        ST_SYNC_WAIT = TAG_RX_ST_SYNC_WAIT,
        ST_GUARD     = TAG_RX_ST_GUARD,
        ST_SLOT      = TAG_RX_ST_SLOT
    } sched_state_e;

    // Counter width able to hold the terminal value with one bit of headroom.
    function automatic int cnt_width(input int term);
        return $clog2(term) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tag_rx_slot_cnt.sv
// ============================================================================
// Module : tag_rx_slot_cnt
// Brief  : Sample counter and slot index for the SLOT state. Counts valid
//          samples, advances the slot index at the end of each slot and
//          flags the final sample of a slot and the last slot of a sync.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tag_rx_slot_cnt
    import tag_rx_pkg::*;
#(
    parameter int NSIG          = 32768 * 8,
    parameter int NLOC_PER_SYNC = 3,
    parameter int IW            = (NLOC_PER_SYNC > 1) ? $clog2(NLOC_PER_SYNC) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          valid_i,
    output logic [IW-1:0] slot_idx_o,
    output logic          sample_tc_o,
    output logic          last_slot_o
);

    localparam int             CW          = cnt_width(NSIG);
    localparam logic [CW-1:0]  SAMPLE_LAST = CW'(NSIG - 1);
    localparam logic [IW-1:0]  SLOT_LAST   = IW'(NLOC_PER_SYNC - 1);

    logic [CW-1:0] cnt_q;
    logic [IW-1:0] idx_q;

    assign sample_tc_o = valid_i && (cnt_q == SAMPLE_LAST);
    assign last_slot_o = (idx_q == SLOT_LAST);
    assign slot_idx_o  = idx_q;

    // Count valid samples; wrap the sample count and step the slot at slot end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (sample_tc_o) begin
            cnt_q <= '0;
            idx_q <= last_slot_o ? '0 : idx_q + 1'b1;
        end else if (valid_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tag_rx_sched.sv
// ============================================================================
// Module : tag_rx_sched
// Brief  : Slot scheduler for the tag receive chain. Arms tag_rx_ctrl, waits
//          for the sync peak strobe, then walks NLOC_PER_SYNC antenna slots
//          of NSIG valid samples each. Re-arms on sync timeout.
//          Optional statistics counters: define TAG_RX_SCHED_STATS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tag_rx_sched
    import tag_rx_pkg::*;
#(
    parameter int NSIG          = 32768 * 8,
    parameter int NLOC_PER_SYNC = 3,
    parameter int GUARD_LEN     = 64,
    parameter int SYNC_TIMEOUT  = 1048576,
    parameter int REG_WIDTH     = 12,
    parameter int IW            = (NLOC_PER_SYNC > 1) ? $clog2(NLOC_PER_SYNC) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 peak_detect_stb,
    input  logic                 rx_valid,
    output logic                 run_rx,
    output logic [REG_WIDTH-1:0] fp_gpio_out,
    output logic [REG_WIDTH-1:0] fp_gpio_ddr,
    output logic                 rx_window,
    output logic [IW-1:0]        slot_idx,
    output logic                 slot_last,
    output logic                 sync_miss,
    output logic [2:0]           sched_state
`ifdef TAG_RX_SCHED_STATS_EN
    ,
    output logic [15:0]          sync_miss_count,
    output logic [15:0]          spur_count,
    output logic [15:0]          sync_count
`endif
);

    localparam int                   TW           = cnt_width(SYNC_TIMEOUT);
    localparam int                   GW           = cnt_width(GUARD_LEN);
    localparam logic [TW-1:0]        TIMEOUT_LAST = TW'(SYNC_TIMEOUT - 1);
    localparam logic [GW-1:0]        GUARD_LAST   = GW'(GUARD_LEN - 1);
    localparam logic [REG_WIDTH-1:0] DDR_MASK     =
        REG_WIDTH'((64'd1 << NLOC_PER_SYNC) - 64'd1);

    sched_state_e         state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [GW-1:0]        guard_q, guard_d;
    logic [REG_WIDTH-1:0] gpio_q, gpio_d;
    logic                 run_rx_q, run_rx_d;
    logic                 slot_last_q, slot_last_d;
    logic                 sync_miss_q, sync_miss_d;

    logic                 w_in_slot;
    logic                 w_slot_clr;
    logic                 w_sample_tc;
    logic                 w_last_slot;

    assign w_in_slot  = (state_q == ST_SLOT);
    assign w_slot_clr = !w_in_slot || !enable;

    tag_rx_slot_cnt #(
        .NSIG          (NSIG),
        .NLOC_PER_SYNC (NLOC_PER_SYNC),
        .IW            (IW)
    ) u_slot_cnt (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (w_slot_clr),
        .valid_i     (rx_valid && w_in_slot),
        .slot_idx_o  (slot_idx),
        .sample_tc_o (w_sample_tc),
        .last_slot_o (w_last_slot)
    );

    // Next-state, timers and registered-output decode; enable low overrides all.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        guard_d     = guard_q;
        gpio_d      = gpio_q;
        slot_last_d = 1'b0;
        sync_miss_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                guard_d = '0;
                gpio_d  = '0;
                if (enable) state_d = ST_ARM;
            end
            ST_ARM: begin
                timer_d = '0;
                state_d = ST_SYNC_WAIT;
            end
            ST_SYNC_WAIT: begin
                // A strobe coinciding with the timeout cycle is accepted.
                if (peak_detect_stb) begin
                    state_d = ST_GUARD;
                    guard_d = GUARD_LAST;
                    timer_d = '0;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d     = ST_ARM;
                    sync_miss_d = 1'b1;
                    timer_d     = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_GUARD: begin
                if (guard_q == '0) begin
                    state_d = ST_SLOT;
                    gpio_d  = REG_WIDTH'(1);
                end else begin
                    guard_d = guard_q - 1'b1;
                end
            end
            ST_SLOT: begin
                if (w_sample_tc) begin
                    if (w_last_slot) begin
                        state_d     = ST_SYNC_WAIT;
                        slot_last_d = 1'b1;
                        timer_d     = '0;
                        gpio_d      = '0;
                    end else begin
                        gpio_d = gpio_q << 1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gpio_d  = '0;
            end
        endcase
        if (!enable) begin
            state_d     = ST_IDLE;
            timer_d     = '0;
            guard_d     = '0;
            gpio_d      = '0;
            slot_last_d = 1'b0;
            sync_miss_d = 1'b0;
        end
        run_rx_d = (state_d == ST_SYNC_WAIT) || (state_d == ST_GUARD) ||
                   (state_d == ST_SLOT);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            guard_q     <= '0;
            gpio_q      <= '0;
            run_rx_q    <= 1'b0;
            slot_last_q <= 1'b0;
            sync_miss_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            guard_q     <= guard_d;
            gpio_q      <= gpio_d;
            run_rx_q    <= run_rx_d;
            slot_last_q <= slot_last_d;
            sync_miss_q <= sync_miss_d;
        end
    end

    assign run_rx      = run_rx_q;
    assign fp_gpio_out = gpio_q;
    assign fp_gpio_ddr = DDR_MASK;
    assign rx_window   = rx_valid && w_in_slot;
    assign slot_last   = slot_last_q;
    assign sync_miss   = sync_miss_q;
    assign sched_state = state_q;

`ifdef TAG_RX_SCHED_STATS_EN
    logic        enable_q;
    logic [15:0] miss_cnt_q, spur_cnt_q, sync_cnt_q;
    logic        w_en_rise;
    logic        w_stb_busy;
    logic        w_stb_take;

    assign w_en_rise  = enable && !enable_q;
    assign w_stb_busy = enable && peak_detect_stb &&
                        ((state_q == ST_GUARD) || (state_q == ST_SLOT));
    assign w_stb_take = enable && peak_detect_stb && (state_q == ST_SYNC_WAIT);

    // Statistics: miss/spur saturate, accepted syncs wrap; cleared on enable rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_q   <= 1'b0;
            miss_cnt_q <= '0;
            spur_cnt_q <= '0;
            sync_cnt_q <= '0;
        end else begin
            enable_q <= enable;
            if (w_en_rise) begin
                miss_cnt_q <= '0;
                spur_cnt_q <= '0;
                sync_cnt_q <= '0;
            end else begin
                if (sync_miss_d && (miss_cnt_q != 16'hFFFF))
                    miss_cnt_q <= miss_cnt_q + 16'd1;
                if (w_stb_busy && (spur_cnt_q != 16'hFFFF))
                    spur_cnt_q <= spur_cnt_q + 16'd1;
                if (w_stb_take)
                    sync_cnt_q <= sync_cnt_q + 16'd1;
            end
        end
    end

    assign sync_miss_count = miss_cnt_q;
    assign spur_count      = spur_cnt_q;
    assign sync_count      = sync_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tag_rx_sched.sv
// ============================================================================
// Module : tb_tag_rx_sched
// Brief  : Directed self-checking bench for tag_rx_sched (NSIG=8, 3 slots,
//          GUARD_LEN=4, SYNC_TIMEOUT=64).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tag_rx_sched;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        peak_detect_stb;
    logic        rx_valid;
    logic        run_rx;
    logic [11:0] fp_gpio_out;
    logic [11:0] fp_gpio_ddr;
    logic        rx_window;
    logic [1:0]  slot_idx;
    logic        slot_last;
    logic        sync_miss;
    logic [2:0]  sched_state;
`ifdef TAG_RX_SCHED_STATS_EN
    logic [15:0] sync_miss_count;
    logic [15:0] spur_count;
    logic [15:0] sync_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    tag_rx_sched #(
        .NSIG          (8),
        .NLOC_PER_SYNC (3),
        .GUARD_LEN     (4),
        .SYNC_TIMEOUT  (64),
        .REG_WIDTH     (12)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .peak_detect_stb (peak_detect_stb),
        .rx_valid        (rx_valid),
        .run_rx          (run_rx),
        .fp_gpio_out     (fp_gpio_out),
        .fp_gpio_ddr     (fp_gpio_ddr),
        .rx_window       (rx_window),
        .slot_idx        (slot_idx),
        .slot_last       (slot_last),
        .sync_miss       (sync_miss),
        .sched_state     (sched_state)
`ifdef TAG_RX_SCHED_STATS_EN
        ,
        .sync_miss_count (sync_miss_count),
        .spur_count      (spur_count),
        .sync_count      (sync_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int n;
    int win [3];

    initial begin
        reset = 1'b0; enable = 1'b0; peak_detect_stb = 1'b0; rx_valid = 1'b0;

        // Reset state
        repeat (10) step();
        chk("rst_state", 32'(sched_state), 32'd0);
        chk("rst_run_rx", 32'(run_rx), 32'd0);
        chk("rst_gpio", 32'(fp_gpio_out), 32'd0);
        chk("rst_idx", 32'(slot_idx), 32'd0);
        chk("rst_last", 32'(slot_last), 32'd0);
        chk("rst_miss", 32'(sync_miss), 32'd0);
        chk("rst_ddr", 32'(fp_gpio_ddr), 32'h007);
        reset = 1'b1;
        step();

        // Enable -> ARM -> SYNC_WAIT
        enable = 1'b1;
        step();
        chk("arm_state", 32'(sched_state), 32'd1);
        chk("arm_run_rx", 32'(run_rx), 32'd0);
        step();
        chk("wait_state", 32'(sched_state), 32'd2);
        chk("wait_run_rx", 32'(run_rx), 32'd1);
        repeat (3) step();

        // Strobe -> GUARD for 4 cycles -> SLOT
        peak_detect_stb = 1'b1;
        step();
        peak_detect_stb = 1'b0;
        chk("guard_entry", 32'(sched_state), 32'd3);
        chk("guard_gpio", 32'(fp_gpio_out), 32'd0);
        repeat (3) step();
        chk("guard_hold", 32'(sched_state), 32'd3);
        step();
        chk("slot_entry", 32'(sched_state), 32'd4);
        chk("slot_entry_gpio", 32'(fp_gpio_out), 32'h001);
        chk("slot_entry_idx", 32'(slot_idx), 32'd0);

        // Continuous valid: 8 samples per slot
        rx_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 8; k++) begin
                step();
                if (k < 7) begin
                    chk("slot_gpio", 32'(fp_gpio_out), 32'(1 << s));
                    chk("slot_last_lo", 32'(slot_last), 32'd0);
                end else if (s < 2) begin
                    chk("slot_switch_gpio", 32'(fp_gpio_out), 32'(1 << (s + 1)));
                    chk("slot_switch_idx", 32'(slot_idx), 32'(s + 1));
                    chk("slot_switch_last", 32'(slot_last), 32'd0);
                end else begin
                    chk("end_gpio", 32'(fp_gpio_out), 32'd0);
                    chk("end_last", 32'(slot_last), 32'd1);
                    chk("end_state", 32'(sched_state), 32'd2);
                    chk("end_idx", 32'(slot_idx), 32'd0);
                end
            end
        end
        rx_valid = 1'b0;
        step();
        chk("last_pulse_end", 32'(slot_last), 32'd0);
        chk("after_end_state", 32'(sched_state), 32'd2);

        // 50% valid: 16 cycles and 8 window pulses per slot
        peak_detect_stb = 1'b1;
        step();
        peak_detect_stb = 1'b0;
        repeat (4) step();
        chk("half_slot_entry", 32'(sched_state), 32'd4);
        for (int i = 0; i < 3; i++) win[i] = 0;
        for (int c = 0; c < 48; c++) begin
            rx_valid = (c % 2 == 1);
            #1;
            if (rx_window === 1'b1) win[c / 16]++;
            step();
            if (c == 47) begin
                chk("half_end_gpio", 32'(fp_gpio_out), 32'd0);
                chk("half_end_last", 32'(slot_last), 32'd1);
            end else if (c % 16 == 15) begin
                chk("half_switch_gpio", 32'(fp_gpio_out), 32'(1 << (c / 16 + 1)));
            end else if (c % 16 == 14) begin
                chk("half_hold_gpio", 32'(fp_gpio_out), 32'(1 << (c / 16)));
            end
        end
        rx_valid = 1'b0;
        chk("win_slot0", 32'(win[0]), 32'd8);
        chk("win_slot1", 32'(win[1]), 32'd8);
        chk("win_slot2", 32'(win[2]), 32'd8);

        // No strobe: 64 SYNC_WAIT cycles, miss + ARM, then fresh wait
        n = 0;
        while (sync_miss !== 1'b1 && n < 200) begin step(); n++; end
        chk("miss1_wait", 32'(n), 32'd64);
        chk("miss1_state", 32'(sched_state), 32'd1);
        chk("miss1_run_rx", 32'(run_rx), 32'd0);
        step();
        chk("miss1_rewait", 32'(sched_state), 32'd2);
        chk("miss1_pulse_end", 32'(sync_miss), 32'd0);
        chk("miss1_run_rx_hi", 32'(run_rx), 32'd1);
        rx_valid = 1'b1;
        #1;
        chk("window_outside_slot", 32'(rx_window), 32'd0);
        rx_valid = 1'b0;
        n = 0;
        while (sync_miss !== 1'b1 && n < 200) begin step(); n++; end
        chk("miss2_wait", 32'(n), 32'd64);
        chk("miss2_state", 32'(sched_state), 32'd1);
        step();

        // Strobe on the timeout cycle wins
        repeat (63) step();
        chk("pre_timeout_state", 32'(sched_state), 32'd2);
        peak_detect_stb = 1'b1;
        step();
        peak_detect_stb = 1'b0;
        chk("tmo_strobe_state", 32'(sched_state), 32'd3);
        chk("tmo_strobe_miss", 32'(sync_miss), 32'd0);

        // Strobe mid-SLOT ignored
        repeat (4) step();
        chk("spur_slot_entry", 32'(sched_state), 32'd4);
        rx_valid = 1'b1;
        repeat (3) step();
        peak_detect_stb = 1'b1;
        step();
        peak_detect_stb = 1'b0;
        chk("spur_state", 32'(sched_state), 32'd4);
        chk("spur_gpio", 32'(fp_gpio_out), 32'h001);
`ifdef TAG_RX_SCHED_STATS_EN
        chk("stat_spur", 32'(spur_count), 32'd1);
        chk("stat_miss", 32'(sync_miss_count), 32'd2);
        chk("stat_sync", 32'(sync_count), 32'd3);
`endif
        repeat (4) step();
        chk("spur_slot1_gpio", 32'(fp_gpio_out), 32'h002);

        // Disable at slot 1, sample 3
        repeat (3) step();
        enable = 1'b0;
        step();
        chk("dis_state", 32'(sched_state), 32'd0);
        chk("dis_gpio", 32'(fp_gpio_out), 32'd0);
        chk("dis_run_rx", 32'(run_rx), 32'd0);
        chk("dis_idx", 32'(slot_idx), 32'd0);
        chk("dis_window", 32'(rx_window), 32'd0);
        step();
        chk("dis_hold", 32'(sched_state), 32'd0);
        rx_valid = 1'b0;

        // Re-enable: fresh ARM and a fresh slot count
        enable = 1'b1;
        step();
        chk("reen_arm", 32'(sched_state), 32'd1);
        chk("reen_run_rx", 32'(run_rx), 32'd0);
        step();
        peak_detect_stb = 1'b1;
        step();
        peak_detect_stb = 1'b0;
        repeat (4) step();
        chk("reen_slot", 32'(sched_state), 32'd4);
        chk("reen_gpio", 32'(fp_gpio_out), 32'h001);
        rx_valid = 1'b1;
        repeat (5) step();
        chk("reen_fresh_gpio", 32'(fp_gpio_out), 32'h001);
        chk("reen_fresh_idx", 32'(slot_idx), 32'd0);
`ifdef TAG_RX_SCHED_STATS_EN
        chk("stat_reen_sync", 32'(sync_count), 32'd1);
        chk("stat_reen_spur", 32'(spur_count), 32'd0);
`endif

        // Asynchronous reset in SLOT, between clock edges
        #2;
        reset = 1'b0;
        #1;
        chk("arst_state", 32'(sched_state), 32'd0);
        chk("arst_gpio", 32'(fp_gpio_out), 32'd0);
        chk("arst_run_rx", 32'(run_rx), 32'd0);
        chk("arst_idx", 32'(slot_idx), 32'd0);
        chk("arst_window", 32'(rx_window), 32'd0);
        chk("arst_ddr", 32'(fp_gpio_ddr), 32'h007);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tag_rx_sched.md
# tag_rx_sched

Slot scheduler for the tag receive chain. Arms `tag_rx_ctrl`, waits for its sync peak strobe, then walks `NLOC_PER_SYNC` location slots of `NSIG` valid samples each, driving the front-panel antenna select and a capture-window qualifier. It re-arms on sync timeout and loops until disabled. It sits between host-register control and `tag_rx_ctrl` / capture logic.

## Interface
Parameters:
- `NSIG`, 32768*8: valid samples per location slot.
- `NLOC_PER_SYNC`, 3: slots per sync (1..REG_WIDTH).
- `GUARD_LEN`, 64: clock cycles between sync strobe and slot 0.
- `SYNC_TIMEOUT`, 1048576: cycles in SYNC_WAIT before re-arm.
- `REG_WIDTH`, 12: fp_gpio width.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-low (asserted at 0).
- `enable`  in  1  level; scheduler runs while high.
- `peak_detect_stb`  in  1  1-cycle sync strobe from `tag_rx_ctrl`.
- `rx_valid`  in  1  sample qualifier from `tag_rx_ctrl`.
- `run_rx`  out  1  to `tag_rx_ctrl.run_rx`.
- `fp_gpio_out`  out  REG_WIDTH  one-hot antenna select in bits [NLOC_PER_SYNC-1:0]; upper bits 0.
- `fp_gpio_ddr`  out  REG_WIDTH  constant mask, low NLOC_PER_SYNC bits = 1.
- `rx_window`  out  1  = `rx_valid` while in SLOT (capture enable).
- `slot_idx`  out  $clog2(NLOC_PER_SYNC)  current slot.
- `slot_last`  out  1  pulse on final valid sample of the last slot.
- `sync_miss`  out  1  1-cycle pulse on timeout.
- `sched_state`  out  3  state encoding.

## Operation
States: IDLE(0), ARM(1), SYNC_WAIT(2), GUARD(3), SLOT(4).
- IDLE: run_rx=0. enable=1 -> ARM.
- ARM: one cycle, run_rx=0 (restarts the `tag_rx_ctrl` search). -> SYNC_WAIT.
- SYNC_WAIT: run_rx=1. Timer counts cycles. On peak_detect_stb -> GUARD, guard counter loaded with GUARD_LEN-1. When the timer reaches SYNC_TIMEOUT-1 without a strobe: pulse sync_miss, -> ARM. A strobe on the same cycle as the timeout wins; no miss is reported.
- GUARD: counter decrements each cycle. At 0 -> SLOT, slot_idx=0, sample count=0.
- SLOT: run_rx=1. fp_gpio_out bit slot_idx = 1. Sample count increments only on rx_valid. On valid sample NSIG-1: if slot_idx < NLOC_PER_SYNC-1, slot_idx+1 and count=0; else pulse slot_last, -> SYNC_WAIT (timer cleared, slot_idx=0). peak_detect_stb in SLOT or GUARD is ignored.
- enable=0 in any state: -> IDLE next cycle. Counters clear, fp_gpio_out=0, run_rx=0. A partial slot is abandoned.
- Counter widths: $clog2 of each terminal value + 1. There is no wrap: every counter is reloaded on its state transition.

## Timing
- All outputs are registered except `rx_window` (AND of rx_valid and registered in-SLOT flag) and `fp_gpio_ddr` (constant).
- Reset: state=IDLE, run_rx=0, fp_gpio_out=0, slot_idx=0, slot_last=0, sync_miss=0, all counters 0. Reset mid-operation aborts immediately (asynchronous).
- enable rise -> ARM next edge. run_rx rises 2 edges after enable.
- Strobe at edge N -> GUARD at N+1 -> SLOT at N+1+GUARD_LEN. fp_gpio_out valid that same edge.
- Antenna switches on the edge after the last valid sample of a slot. slot_last and the return to SYNC_WAIT occur on the same edge.

## Configuration
- `TAG_RX_SCHED_STATS_EN`: defined -> adds outputs `sync_miss_count[15:0]` (saturating count of timeouts), `spur_count[15:0]` (saturating count of strobes ignored in GUARD/SLOT) and `sync_count[15:0]` (wrapping count of accepted strobes). All three clear on reset or on the enable rising edge.
- Not defined -> these ports and their logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package/header `tag_rx_pkg`: state encodings, `TAG_RX_ST_*` constants, width helper for the sample counter.
- One sub-module, `tag_rx_slot_cnt`: loadable sample/slot counter with terminal-count flags, instantiated once in SLOT.
- FSM, guard and timeout timers live in the top module.

## Test plan
Bench parameters: NSIG=8, NLOC_PER_SYNC=3, GUARD_LEN=4, SYNC_TIMEOUT=64.
- Reset low 10 cycles, enable=1, strobe at cycle 20 -> SLOT entered cycle 25; fp_gpio_out 001/010/100 for 8 valid samples each; slot_last once; then SYNC_WAIT.
- rx_valid toggling 50% -> each slot lasts 16 cycles; rx_window pulses exactly 8 times per slot.
- No strobe -> sync_miss pulses at 64-cycle intervals, with one run_rx=0 cycle before each new wait.
- Strobe on the timeout cycle -> GUARD, no sync_miss. Strobe mid-SLOT -> ignored; spur_count=1 with STATS_EN.
- enable=0 at slot 1, sample 3 -> IDLE next edge, fp_gpio_out=0, run_rx=0. Re-enable -> fresh ARM.
- reset asserted in SLOT -> all outputs 0 without waiting for a clock edge. fp_gpio_ddr stays 0x007 throughout.
